// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus and its slave endpoints.
// Holds the slave FSM state encoding, the RW command values and the default
// address/data widths used by both the bus block and the slave ports.
package bus_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned DATA_W_DEF = 8;

  // Value of the first (RW) bit of a frame.
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    WDATA,
    MEM_WR,
    SPLIT,
    SPLIT_WAIT,
    MEM_RD,
    RDATA,
    DONE
  } slave_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/slave_mem.sv
// Single-port synchronous RAM behind a slave port, 2**ADDR_W x DATA_W.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable, writes wdata to mem[addr]
//   addr  - word address
//   wdata - write data
//   rdata - read data, mem[addr] registered (1-cycle latency, old data on write)
// Contents are not reset.
module slave_mem
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/bus_slave_port.sv
// Serial-bus slave endpoint. Deserialises RW/address/write data from the
// master line, performs the access on a local RAM and serialises read data
// back, driving the busy/split/done status lines.
// Ports:
//   CLK, RSTN     - clock (rising) and asynchronous active-low reset
//   B_SEL         - this slave is the decoded target
//   B_UTIL        - bus held by the granted master
//   A_ADD         - address phase valid (RW and address bits on B_BUS_OUT)
//   B_BUS_OUT     - serial line master->slave, LSB first
//   B_BUS_IN      - serial line slave->master, read data LSB first
//   B_SBSY        - slave busy (every state except IDLE)
//   B_SPLIT       - 1-cycle split request pulse
//   B_SPL_RESUME  - arbiter re-granted the split master
//   B_DONE        - 1-cycle transaction complete pulse
// Frame: RW bit then ADDR_W address bits with A_ADD=1; writes follow with
// DATA_W data bits and A_ADD=0. ADDR_W and DATA_W must be at least 2.
module bus_slave_port
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned SPLIT_EN  = 0,
  parameter int unsigned SPLIT_LAT = 4
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic B_SEL,
  input  logic B_UTIL,
  input  logic A_ADD,
  input  logic B_BUS_OUT,
  output logic B_BUS_IN,
  output logic B_SBSY,
  output logic B_SPLIT,
  input  logic B_SPL_RESUME,
  output logic B_DONE
);

  localparam int unsigned CNT_W = $clog2(max_u(ADDR_W, DATA_W) + 1);
  localparam int unsigned LAT_W = $clog2(SPLIT_LAT + 1);

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD  = LAT_W'(SPLIT_LAT);

  slave_state_t      st_q;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LAT_W-1:0]  lat_q;

  logic              act;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign act    = B_SEL & B_UTIL;
  assign mem_we = (st_q == MEM_WR);

  // The RAM re-reads the held address every cycle, so its output stays stable
  // through RDATA; the bit is selected straight from it. Being decoded from
  // st_q, the line drops as soon as reset forces IDLE.
  assign B_BUS_IN = (st_q == RDATA) & (|(mem_rdata & (DATA_W'(1) << cnt_q)));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      st_q    <= IDLE;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      B_SBSY  <= 1'b0;
      B_SPLIT <= 1'b0;
      B_DONE  <= 1'b0;
    end else begin
      B_SPLIT <= 1'b0;
      B_DONE  <= 1'b0;
      unique case (st_q)
        IDLE: begin
          if (act && A_ADD) begin
            rw_q   <= B_BUS_OUT;
            cnt_q  <= '0;
            st_q   <= ADDR;
            B_SBSY <= 1'b1;
          end
        end
        ADDR: begin
          if (!act || !A_ADD) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            B_SBSY <= 1'b0;
          end else begin
            addr_q <= {B_BUS_OUT, addr_q[ADDR_W-1:1]};
            if (cnt_q == ADDR_LAST) begin
              cnt_q <= '0;
              if (rw_q == CMD_WRITE) begin
                st_q <= WDATA;
              end else if (SPLIT_EN != 0) begin
                st_q    <= SPLIT;
                B_SPLIT <= 1'b1;
              end else begin
                st_q <= MEM_RD;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        WDATA: begin
          if (!act || A_ADD) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            B_SBSY <= 1'b0;
          end else begin
            wdata_q <= {B_BUS_OUT, wdata_q[DATA_W-1:1]};
            if (cnt_q == DATA_LAST) begin
              cnt_q <= '0;
              st_q  <= MEM_WR;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        MEM_WR: begin
          st_q   <= DONE;
          B_DONE <= 1'b1;
        end
        SPLIT: begin
          lat_q <= LAT_LOAD;
          st_q  <= SPLIT_WAIT;
        end
        SPLIT_WAIT: begin
          // Bus is released here; only the resume at count zero matters.
          if (lat_q != '0) begin
            lat_q <= lat_q - LAT_W'(1);
          end else if (B_SPL_RESUME) begin
            st_q <= MEM_RD;
          end
        end
        MEM_RD: begin
          cnt_q <= '0;
          st_q  <= RDATA;
        end
        RDATA: begin
          if (!act) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            B_SBSY <= 1'b0;
          end else if (cnt_q == DATA_LAST) begin
            cnt_q  <= '0;
            st_q   <= DONE;
            B_DONE <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          st_q   <= IDLE;
          B_SBSY <= 1'b0;
        end
        default: begin
          st_q   <= IDLE;
          cnt_q  <= '0;
          B_SBSY <= 1'b0;
        end
      endcase
    end
  end

  slave_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule
